// File: rtl/vga_vram_arbiter_pkg.sv
// Shared constants, pixel type and arbiter state encoding for the VGA VRAM path.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int H_OFFSET = 49;
   localparam int V_OFFSET = 34;
   localparam int ADDR_W   = 15;
   localparam int DATA_W   = 3;

   typedef logic [DATA_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISP_RD  = 2'd1,
      DISP_CAP = 2'd2,
      WR       = 2'd3
   } arb_state_e;

   // Number of framebuffer cells per scan line after downscaling.
   function automatic int cells_per_line(input int shift);
      return H_ACTIVE >> shift;
   endfunction

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// Bus between the counter block / writer / VRAM / RGB stage and the VRAM arbiter.
interface vga_vram_arbiter_if #(
   parameter int ADDR_W = vga_pkg::ADDR_W,
   parameter int DATA_W = vga_pkg::DATA_W
);
   logic              pix_tick;
   logic [9:0]        qh;
   logic [9:0]        qv;
   logic              h_on;
   logic              v_on;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;

   // wr_req sampled at the end of the wr_ack cycle is taken as a new request.
   modport slave (
      input  pix_tick, qh, qv, h_on, v_on,
      input  wr_req, wr_addr, wr_data, mem_rdata,
      output wr_ack, mem_addr, mem_we, mem_wdata, pix_data, pix_valid
   );

   modport master (
      output pix_tick, qh, qv, h_on, v_on,
      output wr_req, wr_addr, wr_data, mem_rdata,
      input  wr_ack, mem_addr, mem_we, mem_wdata, pix_data, pix_valid
   );
endinterface

// File: rtl/vga_addr_gen.sv
// Registered (qh, qv) to framebuffer-cell address mapper with a direct-load path.
module vga_addr_gen #(
   parameter int ADDR_W   = vga_pkg::ADDR_W,
   parameter int SHIFT    = 2,
   parameter int H_OFFSET = vga_pkg::H_OFFSET,
   parameter int V_OFFSET = vga_pkg::V_OFFSET
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load_xy,
   input  logic              i_load_addr,
   input  logic [9:0]        i_qh,
   input  logic [9:0]        i_qv,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [ADDR_W-1:0] o_addr
);
   import vga_pkg::*;

   localparam int COLS = cells_per_line(SHIFT);

   logic [9:0]        w_dx;
   logic [9:0]        w_dy;
   logic [ADDR_W-1:0] w_map;
   logic [ADDR_W-1:0] r_addr;

   // Unsigned wrap-around is fine: callers only map coordinates inside the active area.
   assign w_dx  = i_qh - 10'(H_OFFSET);
   assign w_dy  = i_qv - 10'(V_OFFSET);
   assign w_map = ADDR_W'(32'(w_dy >> SHIFT) * 32'(COLS) + 32'(w_dx >> SHIFT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
      end else if (i_load_addr) begin
         r_addr <= i_addr;
      end else if (i_load_xy) begin
         r_addr <= w_map;
      end
   end

   assign o_addr = r_addr;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, writer fills free slots.
// Build option: VGA_ARB_BLANK_WR_ONLY_EN restricts write grants to vertical blanking.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no memory access; arbitrates tick / write request
// DISP_RD  | display read address on the bus; ticks here are ignored
// DISP_CAP | read data valid, captured into pix_data; arbitrates
// WR       | write strobe on the bus, wr_ack high; arbitrates
module vga_vram_arbiter #(
   parameter int ADDR_W   = vga_pkg::ADDR_W,
   parameter int DATA_W   = vga_pkg::DATA_W,
   parameter int SHIFT    = 2,
   parameter int H_OFFSET = vga_pkg::H_OFFSET,
   parameter int V_OFFSET = vga_pkg::V_OFFSET
) (
   input  logic                reloj,
   input  logic                resetM,
   vga_vram_arbiter_if.slave   bus
);
   import vga_pkg::*;

   arb_state_e        r_state;
   arb_state_e        w_next;
   logic              w_active;
   logic              w_arb;
   logic              w_disp;
   logic              w_blank_tick;
   logic              w_wr_ok;
   logic              w_go_rd;
   logic              w_go_wr;
   logic              r_mem_we;
   logic              r_wr_ack;
   logic              r_pix_valid;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_pix_data;
   logic [ADDR_W-1:0] w_mem_addr;

   assign w_active     = bus.h_on & bus.v_on;
   assign w_arb        = (r_state != DISP_RD);
   assign w_disp       = bus.pix_tick & w_active;
   assign w_blank_tick = bus.pix_tick & ~w_active & w_arb;

`ifdef VGA_ARB_BLANK_WR_ONLY_EN
   assign w_wr_ok = bus.wr_req & ~bus.v_on;
`else
   assign w_wr_ok = bus.wr_req;
`endif

   always_comb begin
      w_next = IDLE;
      case (r_state)
         DISP_RD: w_next = DISP_CAP;
         default: begin
            if (w_disp) begin
               w_next = DISP_RD;
            end else if (w_wr_ok) begin
               w_next = WR;
            end else begin
               w_next = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge reloj or posedge resetM) begin
      if (resetM) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   assign w_go_rd = (w_next == DISP_RD);
   assign w_go_wr = (w_next == WR);

   // Outputs are registered off the next state so they line up with the state they describe.
   always_ff @(posedge reloj or posedge resetM) begin
      if (resetM) begin
         r_mem_we    <= 1'b0;
         r_wr_ack    <= 1'b0;
         r_mem_wdata <= '0;
         r_pix_data  <= '0;
         r_pix_valid <= 1'b0;
      end else begin
         r_mem_we <= w_go_wr;
         r_wr_ack <= w_go_wr;
         if (w_go_wr) begin
            r_mem_wdata <= bus.wr_data;
         end
         if (r_state == DISP_CAP) begin
            r_pix_data  <= bus.mem_rdata;
            r_pix_valid <= 1'b1;
         end else if (w_blank_tick) begin
            r_pix_data  <= '0;
            r_pix_valid <= 1'b1;
         end else begin
            r_pix_valid <= 1'b0;
         end
      end
   end

   vga_addr_gen #(
      .ADDR_W   (ADDR_W),
      .SHIFT    (SHIFT),
      .H_OFFSET (H_OFFSET),
      .V_OFFSET (V_OFFSET)
   ) u_addr_gen (
      .clk         (reloj),
      .rst         (resetM),
      .i_load_xy   (w_go_rd),
      .i_load_addr (w_go_wr),
      .i_qh        (bus.qh),
      .i_qv        (bus.qv),
      .i_addr      (bus.wr_addr),
      .o_addr      (w_mem_addr)
   );

   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.wr_ack    = r_wr_ack;
   assign bus.pix_data  = r_pix_data;
   assign bus.pix_valid = r_pix_valid;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed, table-driven bench for vga_vram_arbiter plus multi-cycle corner sequences.
module tb_vga_vram_arbiter;

   logic clk;
   logic rst;

   vga_vram_arbiter_if #(.ADDR_W(15), .DATA_W(3)) bus ();

   vga_vram_arbiter dut (
      .reloj  (clk),
      .resetM (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic        tick;
      logic [9:0]  qh;
      logic [9:0]  qv;
      logic        h_on;
      logic        v_on;
      logic        req;
      logic [14:0] waddr;
      logic [2:0]  wdata;
      logic [2:0]  rdata;
      logic        e_we;
      logic        e_ack;
      logic [14:0] e_addr;
      logic [2:0]  e_wdata;
      logic        e_pv;
      logic [2:0]  e_pd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic tick, input int qh, input int qv,
                               input logic h_on, input logic v_on, input logic req,
                               input int waddr, input int wdata, input int rdata,
                               input logic e_we, input logic e_ack, input int e_addr,
                               input int e_wdata, input logic e_pv, input int e_pd);
      vec_t v;
      v.tick = tick;  v.qh = 10'(qh);  v.qv = 10'(qv);
      v.h_on = h_on;  v.v_on = v_on;  v.req = req;
      v.waddr = 15'(waddr);  v.wdata = 3'(wdata);  v.rdata = 3'(rdata);
      v.e_we = e_we;  v.e_ack = e_ack;  v.e_addr = 15'(e_addr);
      v.e_wdata = 3'(e_wdata);  v.e_pv = e_pv;  v.e_pd = 3'(e_pd);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic tick, input int qh, input int qv, input logic h_on,
                        input logic v_on, input logic req, input int waddr, input int wdata,
                        input int rdata);
      bus.pix_tick  = tick;
      bus.qh        = 10'(qh);
      bus.qv        = 10'(qv);
      bus.h_on      = h_on;
      bus.v_on      = v_on;
      bus.wr_req    = req;
      bus.wr_addr   = 15'(waddr);
      bus.wr_data   = 3'(wdata);
      bus.mem_rdata = 3'(rdata);
   endtask

   task automatic check_all(input string tag, input logic we, input logic ack, input int addr,
                            input int wdata, input logic pv, input int pd);
      check({tag, ".mem_we"},    32'(bus.mem_we),    32'(we));
      check({tag, ".wr_ack"},    32'(bus.wr_ack),    32'(ack));
      check({tag, ".mem_addr"},  32'(bus.mem_addr),  32'(addr));
      check({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(wdata));
      check({tag, ".pix_valid"}, 32'(bus.pix_valid), 32'(pv));
      check({tag, ".pix_data"},  32'(bus.pix_data),  32'(pd));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // tick qh qv h v req waddr wdata rdata | we ack addr wdata pv pd
      vecs.push_back(mk(0,   0,   0, 0, 0, 0,    0, 0, 0,  0, 0,     0, 0, 0, 0));
      vecs.push_back(mk(1,  49,  34, 1, 1, 0,    0, 0, 5,  0, 0,     0, 0, 0, 0));
      vecs.push_back(mk(0,  49,  34, 1, 1, 0,    0, 0, 5,  0, 0,     0, 0, 0, 0));
      vecs.push_back(mk(0,  49,  34, 1, 1, 0,    0, 0, 5,  0, 0,     0, 0, 1, 5));
      vecs.push_back(mk(0,  50,  34, 1, 1, 0,    0, 0, 2,  0, 0,     0, 0, 0, 5));
      vecs.push_back(mk(1,  56,  43, 1, 1, 0,    0, 0, 2,  0, 0,   321, 0, 0, 5));
      vecs.push_back(mk(0,  56,  43, 1, 1, 0,    0, 0, 2,  0, 0,   321, 0, 0, 5));
      vecs.push_back(mk(0,  56,  43, 1, 1, 0,    0, 0, 2,  0, 0,   321, 0, 1, 2));
      vecs.push_back(mk(0,   0,   0, 0, 0, 1, 1234, 6, 0,  1, 1,  1234, 6, 0, 2));
      vecs.push_back(mk(0,   0,   0, 0, 0, 0,    0, 0, 0,  0, 0,  1234, 6, 0, 2));
      vecs.push_back(mk(1,  10,  40, 0, 1, 0,    0, 0, 7,  0, 0,  1234, 6, 1, 0));
      vecs.push_back(mk(0,  11,  40, 0, 1, 0,    0, 0, 7,  0, 0,  1234, 6, 0, 0));
      vecs.push_back(mk(1, 688, 513, 1, 1, 0,    0, 0, 7,  0, 0, 19199, 6, 0, 0));
      vecs.push_back(mk(0, 688, 513, 1, 1, 0,    0, 0, 7,  0, 0, 19199, 6, 0, 0));
      vecs.push_back(mk(0, 688, 513, 1, 1, 0,    0, 0, 7,  0, 0, 19199, 6, 1, 7));
      vecs.push_back(mk(1, 100,  10, 1, 0, 1,   77, 3, 0,  1, 1,    77, 3, 1, 0));
      vecs.push_back(mk(0, 101,  10, 1, 0, 1,   78, 4, 0,  1, 1,    78, 4, 0, 0));
      vecs.push_back(mk(0, 102,  10, 1, 0, 0,    0, 0, 0,  0, 0,    78, 4, 0, 0));
      vecs.push_back(mk(1,  49,  34, 1, 1, 0,    0, 0, 1,  0, 0,     0, 4, 0, 0));
      vecs.push_back(mk(1,  53,  34, 1, 1, 0,    0, 0, 1,  0, 0,     0, 4, 0, 0));
      vecs.push_back(mk(0,  53,  34, 1, 1, 0,    0, 0, 1,  0, 0,     0, 4, 1, 1));
      vecs.push_back(mk(0,  54,  34, 1, 1, 0,    0, 0, 1,  0, 0,     0, 4, 0, 1));
      vecs.push_back(mk(1,   5,   5, 0, 0, 1,  900, 5, 0,  1, 1,   900, 5, 1, 0));
      vecs.push_back(mk(1,  57,  34, 1, 1, 1,  901, 6, 3,  0, 0,     2, 5, 0, 0));
      vecs.push_back(mk(0,  57,  34, 1, 1, 1,  901, 6, 3,  0, 0,     2, 5, 0, 0));
      vecs.push_back(mk(0,   0,   0, 0, 0, 1,  901, 6, 3,  1, 1,   901, 6, 1, 3));
      vecs.push_back(mk(0,   0,   0, 0, 0, 0,    0, 0, 3,  0, 0,   901, 6, 0, 3));

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      step();
      check_all("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].tick, 32'(vecs[i].qh), 32'(vecs[i].qv), vecs[i].h_on, vecs[i].v_on,
               vecs[i].req, 32'(vecs[i].waddr), 32'(vecs[i].wdata), 32'(vecs[i].rdata));
         step();
         check_all($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_ack, 32'(vecs[i].e_addr),
                   32'(vecs[i].e_wdata), vecs[i].e_pv, 32'(vecs[i].e_pd));
      end

      // Reset asserted while a write is on the bus: outputs clear at once, no ack survives.
      drive(0, 0, 0, 0, 0, 1, 100, 5, 0);
      step();
      check("rstwr.pre_we",   32'(bus.mem_we),   32'd1);
      check("rstwr.pre_addr", 32'(bus.mem_addr), 32'd100);
      #2 rst = 1'b1;
      #1;
      check_all("rstwr.async", 0, 0, 0, 0, 0, 0);
      step();
      check_all("rstwr.held", 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step();
      check_all("rstwr.retry", 1, 1, 100, 5, 0, 0);
      bus.wr_req = 1'b0;
      step();
      check("rstwr.done_we", 32'(bus.mem_we), 32'd0);

`ifndef VGA_ARB_BLANK_WR_ONLY_EN
      // Write request colliding with an active tick: read first, write two cycles later.
      drive(1, 49, 34, 1, 1, 1, 500, 2, 4);
      step();
      check("coll.rd_we",   32'(bus.mem_we),   32'd0);
      check("coll.rd_ack",  32'(bus.wr_ack),   32'd0);
      check("coll.rd_addr", 32'(bus.mem_addr), 32'd0);
      bus.pix_tick = 1'b0;
      step();
      check("coll.cap_we",  32'(bus.mem_we), 32'd0);
      check("coll.cap_ack", 32'(bus.wr_ack), 32'd0);
      step();
      check_all("coll.wr", 1, 1, 500, 2, 1, 4);
      bus.wr_req = 1'b0;
      step();
      check("coll.done_we", 32'(bus.mem_we), 32'd0);
`else
      // Writes wait for vertical blanking, then go through within one cycle.
      drive(0, 60, 40, 1, 1, 1, 300, 7, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("vblank.hold%0d_ack", k), 32'(bus.wr_ack), 32'd0);
         check($sformatf("vblank.hold%0d_we", k),  32'(bus.mem_we), 32'd0);
      end
      bus.v_on = 1'b0;
      step();
      check("vblank.ack",  32'(bus.wr_ack),   32'd1);
      check("vblank.addr", 32'(bus.mem_addr), 32'd300);
      bus.wr_req = 1'b0;
      step();
      check("vblank.done_we", 32'(bus.mem_we), 32'd0);
`endif

      // Blanking tick: black pixel, no read, and four queued writes back to back.
      drive(1, 0, 0, 0, 0, 1, 200, 1, 6);
      step();
      check_all("blank.w0", 1, 1, 200, 1, 1, 0);
      bus.pix_tick = 1'b0;
      for (int k = 1; k < 4; k++) begin
         bus.wr_addr = 15'(200 + k);
         bus.wr_data = 3'(k + 1);
         step();
         check_all($sformatf("blank.w%0d", k), 1, 1, 200 + k, k + 1, 0, 0);
      end
      bus.wr_req = 1'b0;
      step();
      check("blank.done_we",  32'(bus.mem_we), 32'd0);
      check("blank.done_ack", 32'(bus.wr_ack), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
